// File: rtl/alu_pkg.sv
// Shared ALU definitions: the 4-bit opcode type and its encodings.
// The ALU-control decoder and the ALU both import this package.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND  = 4'b0000;
    localparam alu_op_t ALU_OR   = 4'b0001;
    localparam alu_op_t ALU_ADD  = 4'b0010;
    localparam alu_op_t ALU_XOR  = 4'b0011;
    localparam alu_op_t ALU_SLL  = 4'b0100;
    localparam alu_op_t ALU_SRL  = 4'b0101;
    localparam alu_op_t ALU_SUB  = 4'b0110;
    localparam alu_op_t ALU_SLT  = 4'b0111;
    localparam alu_op_t ALU_SLTU = 4'b1000;
    localparam alu_op_t ALU_SRA  = 4'b1001;
    localparam alu_op_t ALU_NOR  = 4'b1100;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU core: produces the next result from A, B and Sel.
// Unused opcodes return zero so nothing undefined reaches the result register.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Sel,
    output logic [WIDTH-1:0] Result
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   w_shamt;
    logic             w_ltSigned;
    logic             w_ltUnsigned;
    logic [WIDTH-1:0] w_sra;

    // Only the low log2(WIDTH) bits of B select the shift distance.
    assign w_shamt      = B[SHW-1:0];
    assign w_ltSigned   = $signed(A) < $signed(B);
    assign w_ltUnsigned = A < B;
    assign w_sra        = $unsigned($signed(A) >>> w_shamt);

    always_comb begin
        Result = '0;
        case (Sel)
            ALU_AND:  Result = A & B;
            ALU_OR:   Result = A | B;
            ALU_ADD:  Result = A + B;
            ALU_XOR:  Result = A ^ B;
            ALU_SLL:  Result = A << w_shamt;
            ALU_SRL:  Result = A >> w_shamt;
            ALU_SUB:  Result = A - B;
            ALU_SLT:  Result = {{(WIDTH-1){1'b0}}, w_ltSigned};
            ALU_SLTU: Result = {{(WIDTH-1){1'b0}}, w_ltUnsigned};
            ALU_SRA:  Result = w_sra;
            ALU_NOR:  Result = ~(A | B);
            default:  Result = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered ALU for the execute stage: one result per cycle, visible after
// the capturing edge, with a Zero flag derived from the registered value.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Sel,
    output logic [WIDTH-1:0] Out,
    output logic             Zero
);

    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] r_out;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .A      (A),
        .B      (B),
        .Sel    (Sel),
        .Result (w_next)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_out <= '0;
        end else begin
            r_out <= w_next;
        end
    end

    // Zero looks only at the register, never at the pending next value.
    assign Out  = r_out;
    assign Zero = (r_out == '0);

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for the registered ALU: expected results are queued when
// operands are driven and compared one edge later.
module tb_alu;

    localparam int WIDTH = 8;

    logic             Clk = 1'b0;
    logic             Rst;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       Sel;
    logic [WIDTH-1:0] Out;
    logic             Zero;

    int compared   = 0;
    int mismatched = 0;

    logic [WIDTH-1:0] expQ[$];

    typedef struct {
        string      tag;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] exp;
    } vec_t;

    vec_t vecQ[$];

    always #5 Clk = ~Clk;

    alu #(
        .WIDTH (WIDTH)
    ) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .A    (A),
        .B    (B),
        .Sel  (Sel),
        .Out  (Out),
        .Zero (Zero)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel, input logic [7:0] exp);
        @(negedge Clk);
        A   = a;
        B   = b;
        Sel = sel;
        expQ.push_back(exp);
    endtask

    task automatic collectResult(input string tag);
        logic [7:0] exp;
        @(posedge Clk);
        #1;
        exp = expQ.pop_front();
        checkOutput({tag, " out"}, Out, exp);
        checkOutput({tag, " zero"}, {7'b0, Zero}, {7'b0, (exp == 8'h00)});
    endtask

    // Reference written independently of the RTL: integer arithmetic and
    // bit-by-bit arithmetic shifting.
    function automatic logic [7:0] refModel(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        int         sh;
        int         sa;
        int         sb;
        logic [7:0] r;
        sh = int'(b[2:0]);
        sa = a[7] ? int'(a) - 256 : int'(a);
        sb = b[7] ? int'(b) - 256 : int'(b);
        r  = 8'h00;
        case (sel)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = 8'((int'(a) + int'(b)) % 256);
            4'd3:  r = a ^ b;
            4'd4:  r = 8'((int'(a) << sh) & 255);
            4'd5:  r = 8'(int'(a) >> sh);
            4'd6:  r = 8'((int'(a) - int'(b) + 256) % 256);
            4'd7:  r = (sa < sb) ? 8'h01 : 8'h00;
            4'd8:  r = (int'(a) < int'(b)) ? 8'h01 : 8'h00;
            4'd9: begin
                r = a;
                for (int k = 0; k < sh; k++) r = {r[7], r[7:1]};
            end
            4'd12: r = ~(a | b);
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecQ.push_back('{"add 55+aa",   8'h55, 8'hAA, 4'b0010, 8'hFF});
        vecQ.push_back('{"add 00+00",   8'h00, 8'h00, 4'b0010, 8'h00});
        vecQ.push_back('{"add ff+01",   8'hFF, 8'h01, 4'b0010, 8'h00});
        vecQ.push_back('{"sub aa-55",   8'hAA, 8'h55, 4'b0110, 8'h55});
        vecQ.push_back('{"sub ff-ff",   8'hFF, 8'hFF, 4'b0110, 8'h00});
        vecQ.push_back('{"sub 00-01",   8'h00, 8'h01, 4'b0110, 8'hFF});
        vecQ.push_back('{"and cc,aa",   8'hCC, 8'hAA, 4'b0000, 8'h88});
        vecQ.push_back('{"and aa,55",   8'hAA, 8'h55, 4'b0000, 8'h00});
        vecQ.push_back('{"or cc,aa",    8'hCC, 8'hAA, 4'b0001, 8'hEE});
        vecQ.push_back('{"or 00,00",    8'h00, 8'h00, 4'b0001, 8'h00});
        vecQ.push_back('{"xor cc,aa",   8'hCC, 8'hAA, 4'b0011, 8'h66});
        vecQ.push_back('{"nor cc,aa",   8'hCC, 8'hAA, 4'b1100, 8'h11});
        vecQ.push_back('{"sll 81<<1",   8'h81, 8'h01, 4'b0100, 8'h02});
        vecQ.push_back('{"srl 81>>1",   8'h81, 8'h01, 4'b0101, 8'h40});
        vecQ.push_back('{"sra 81>>>1",  8'h81, 8'h01, 4'b1001, 8'hC0});
        vecQ.push_back('{"sra 80>>>7",  8'h80, 8'h0F, 4'b1001, 8'hFF});
        vecQ.push_back('{"sll 01<<7",   8'h01, 8'hFF, 4'b0100, 8'h80});
        vecQ.push_back('{"sll masked",  8'h01, 8'hF8, 4'b0100, 8'h01});
        vecQ.push_back('{"slt 80,7f",   8'h80, 8'h7F, 4'b0111, 8'h01});
        vecQ.push_back('{"sltu 80,7f",  8'h80, 8'h7F, 4'b1000, 8'h00});
        vecQ.push_back('{"slt 7f,80",   8'h7F, 8'h80, 4'b0111, 8'h00});
        vecQ.push_back('{"sltu 7f,80",  8'h7F, 8'h80, 4'b1000, 8'h01});
        vecQ.push_back('{"invalid 1111", 8'hAA, 8'h55, 4'b1111, 8'h00});
        vecQ.push_back('{"invalid 1010", 8'hAA, 8'h55, 4'b1010, 8'h00});
        vecQ.push_back('{"invalid 1011", 8'hAA, 8'h55, 4'b1011, 8'h00});
        vecQ.push_back('{"invalid 1101", 8'hAA, 8'h55, 4'b1101, 8'h00});
        vecQ.push_back('{"invalid 1110", 8'hAA, 8'h55, 4'b1110, 8'h00});

        Rst = 1'b0;
        A   = '0;
        B   = '0;
        Sel = '0;
        #1;
        Rst = 1'b1;
        #1;
        checkOutput("reset async out", Out, 8'h00);
        checkOutput("reset async zero", {7'b0, Zero}, 8'h01);

        // Clock edges while reset is held must not disturb the cleared state.
        A   = 8'h55;
        B   = 8'hAA;
        Sel = 4'b0010;
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("reset held out", Out, 8'h00);
        checkOutput("reset held zero", {7'b0, Zero}, 8'h01);
        @(negedge Clk);
        Rst = 1'b0;

        foreach (vecQ[i]) begin
            applyStimulus(vecQ[i].a, vecQ[i].b, vecQ[i].sel, vecQ[i].exp);
            collectResult(vecQ[i].tag);
        end

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [3:0] rs;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 4'($urandom_range(0, 15));
            applyStimulus(ra, rb, rs, refModel(ra, rb, rs));
            collectResult($sformatf("rand %0d sel %0h", i, rs));
        end

        // Reset arriving mid-cycle clears Out without any clock edge.
        applyStimulus(8'h55, 8'hAA, 4'b0010, 8'hFF);
        collectResult("pre-reset add");
        #2;
        Rst = 1'b1;
        #1;
        checkOutput("mid-cycle reset out", Out, 8'h00);
        checkOutput("mid-cycle reset zero", {7'b0, Zero}, 8'h01);

        // Operands presented under reset are dropped.
        @(negedge Clk);
        A   = 8'hCC;
        B   = 8'hAA;
        Sel = 4'b0001;
        @(posedge Clk);
        #1;
        checkOutput("discard under reset", Out, 8'h00);

        // New operands change nothing until the next rising edge.
        @(negedge Clk);
        Rst = 1'b0;
        A   = 8'h01;
        B   = 8'h02;
        Sel = 4'b0010;
        #1;
        checkOutput("latency hold out", Out, 8'h00);
        checkOutput("latency hold zero", {7'b0, Zero}, 8'h01);
        @(posedge Clk);
        #1;
        checkOutput("latency update out", Out, 8'h03);
        checkOutput("latency update zero", {7'b0, Zero}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered WIDTH-bit arithmetic/logic unit. The default is 8 bits.
- Sel picks the operation applied to operands A and B.
- The result is captured on the rising Clk edge. Out therefore shows the result one cycle after the operands are presented.
- Zero flags an all-zero registered result. The block sits in the datapath execute stage and is driven by a 4-bit ALU-control decoder.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be at least 2.

Ports:
- Clk  input  1  system clock; rising-edge active.
- Rst  input  1  asynchronous, active-high reset.
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand; its low log2(WIDTH) bits are the shift amount for shift operations.
- Sel  input  4  operation select.
- Out  output  WIDTH  registered result.
- Zero  output  1  high when Out is all zeros.

Behaviour:
- One clock; Rst is asynchronous and active-high.
- While Rst is high: Out = 0 and Zero = 1, immediately and independent of Clk.
- Releasing Rst takes effect at the next rising Clk edge. Rst asserted mid-operation discards any pending result.
- Latency: result(A, B, Sel) is sampled at rising edge N and appears on Out after edge N. It is held until the next edge. There is no handshake; a new operation is accepted every cycle.
- Zero is combinational from the Out register: Zero = (Out == 0). It never reflects the unregistered next value.
- Sel encoding:
  - 0000 AND: A & B
  - 0001 OR: A | B
  - 0010 ADD: A + B, modulo 2^WIDTH; carry discarded
  - 0011 XOR: A ^ B
  - 0100 SLL: A << B[log2(WIDTH)-1:0], zero fill
  - 0101 SRL: A >> shamt, zero fill
  - 0110 SUB: A - B, modulo 2^WIDTH; borrow discarded
  - 0111 SLT: 1 if signed(A) < signed(B), else 0, zero-extended to WIDTH
  - 1000 SLTU: 1 if unsigned A < unsigned B, else 0, zero-extended
  - 1001 SRA: A >>> shamt, sign fill
  - 1100 NOR: ~(A | B)
  - All other codes (1010, 1011, 1101, 1110, 1111) are invalid. Invalid produces Out = 0, so Zero = 1. No error output.
- Arithmetic wrap-around:
  - ADD 0xFF + 0x01 gives 0x00 with Zero = 1.
  - SUB 0x00 - 0x01 gives 0xFF.
  - Overflow and carry are not reported.
- SLT must use the true signed comparison, not the sign bit of the subtraction. Example: 0x80 vs 0x7F gives 1.
- Shift amounts of WIDTH or more cannot occur, because only the low log2(WIDTH) bits of B are used.
- No X propagation from unused Sel codes. The default branch of the select logic assigns 0.

Decomposition:
- Shared package alu_pkg holds:
  - the 4-bit opcode localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SRA, ALU_NOR
  - the typedef for alu_op_t
  The control decoder reuses these.
- One natural sub-module, alu_comb:
  - purely combinational; computes the next result from A, B and Sel
  - the top module alu adds only the Out register (async reset) and the Zero compare.

Test Plan:
- ADD: A=0x55, B=0xAA, Sel=0010 -> after one edge Out=0xFF, Zero=0. Also A=0x00, B=0x00 -> Out=0x00, Zero=1.
- SUB: A=0xAA, B=0x55, Sel=0110 -> Out=0x55, Zero=0. A=0xFF, B=0xFF -> Out=0x00, Zero=1. A=0x00, B=0x01 -> Out=0xFF.
- Logic:
  - AND 0xCC & 0xAA -> 0x88.
  - AND 0xAA & 0x55 -> 0x00, Zero=1.
  - OR 0xCC | 0xAA -> 0xEE.
  - OR 0x00 | 0x00 -> 0x00, Zero=1.
  - XOR 0xCC ^ 0xAA -> 0x66.
  - NOR 0xCC, 0xAA -> 0x11.
- Shifts and compares:
  - SLL 0x81 by 1 -> 0x02.
  - SRL 0x81 by 1 -> 0x40.
  - SRA 0x81 by 1 -> 0xC0.
  - SLT A=0x80, B=0x7F -> 0x01.
  - SLTU with the same operands -> 0x00.
- Invalid select: A=0xAA, B=0x55, Sel=1111 -> Out=0x00, Zero=1. Repeat for 1010, 1011, 1101, 1110.
- Reset and latency:
  - Assert Rst mid-cycle while Out=0xFF -> Out=0x00 and Zero=1 immediately, without a clock edge.
  - Apply new operands -> Out stays unchanged until the next rising Clk edge, then updates within one cycle.
